register_file_8x16: RTL and testbench
=====================================

Name: register_file_8x16

Overview:
- 8-entry general-purpose register file for the single-cycle RISC datapath.
- Each read port is an 8-to-1 selection over the stored registers, indexed by a 3-bit address (bit 2 = S2 ... bit 0 = S0).
- Supplies operand A and operand B to the ALU.
- Captures the write-back result on the rising clock edge.

Parameters:
- WIDTH, 16, data width of each register and of every data port.
- R0_ZERO, 1, when 1, register 0 is hardwired to zero and ignores writes; when 0, register 0 is a normal register.
- BYPASS, 0, when 1, a read of the register being written in the same cycle returns WD (write-through); when 0, it returns the stored value.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous clear of all registers.
- WE  input  1  write enable.
- WA  input  3  write address.
- WD  input  WIDTH  write data.
- RA1  input  3  read address, port 1.
- RA2  input  3  read address, port 2.
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.
- WCOUNT  output  8  number of committed writes, wraps modulo 256 (debug).

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset: while RST_N=0, all eight registers are 0 and WCOUNT is 0, independent of CLK. RD1 and RD2 therefore read 0. Release is synchronous-safe: the first capture happens on the first rising CLK edge with RST_N=1.
- Write: on a rising CLK edge with RST_N=1, CLR=0 and WE=1, register[WA] takes WD.
  - Exception: R0_ZERO=1 and WA=0, in which case no register changes.
  - All other registers hold.
- WCOUNT: increments by 1 on every edge where a write is committed.
  - Blocked writes to R0 with R0_ZERO=1 do not count.
  - Wrap: 255 goes to 0.
- Clear: on a rising edge with CLR=1, all registers become 0 and WCOUNT becomes 0.
  - CLR has priority over WE; a simultaneous write is discarded.
- Read: RD1 = register[RA1] and RD2 = register[RA2], purely combinational with zero latency.
  - Both ports may address the same register.
  - RA1=0 or RA2=0 with R0_ZERO=1 always reads 0.
- Read-during-write, BYPASS=0: a read of the same address during a write returns the old value until the edge, and the new value immediately after the edge.
- Read-during-write, BYPASS=1: when WE=1, CLR=0, RAx=WA and the write is not a blocked R0 write, RDx = WD combinationally in the same cycle.
- Unknowns: X or Z on WA while WE=1 must not corrupt any register other than the one selected once WA resolves. The bench does not drive this case; the implementation must not infer latches.
- Reset mid-operation: asserting RST_N low at any time, including between edges or coincident with an edge, forces all state to 0 immediately. A write on the same edge as the reset assertion is lost.
- No internal FSM beyond the register array and the write counter. The single-cycle datapath requires write-back to be visible on the next cycle's reads.

Test Plan:
- Reset: hold RST_N=0 with RA1=3 and RA2=7 -> RD1=0, RD2=0, WCOUNT=0. Release, then write WA=3, WD=16'h00A5 -> RD1=16'h00A5 after the edge, WCOUNT=1.
- Fill and address sweep: write 16'h1111*k to registers k=1..7, then sweep RA1 over 0..7 and RA2 over 7..0 -> RD1=16'h1111*RA1 and RD2=16'h1111*RA2, with register 0 reading 0 (R0_ZERO=1). WCOUNT=7.
- R0 protection: write WA=0, WD=16'hFFFF -> RD1 at RA1=0 stays 0 and WCOUNT is unchanged. Repeat with R0_ZERO=0 -> reads 16'hFFFF and WCOUNT increments.
- Read-during-write: WA=RA1=5, WD=16'hBEEF, old value 16'h5555. With BYPASS=0 -> RD1=16'h5555 before the edge and 16'hBEEF after. With BYPASS=1 -> RD1=16'hBEEF in the same cycle.
- Clear priority: CLR=1 and WE=1 with WA=2, WD=16'h1234 on the same edge -> all registers 0, RD at RA=2 is 0, WCOUNT=0.
- Async reset and wrap: perform 256 writes -> WCOUNT returns to 0. Then pull RST_N low mid-cycle, 2 ns after an edge -> RD1 and RD2 drop to 0 without waiting for a CLK edge.

Source files
------------

// File: rtl/register_file_8x16.sv
// 8-entry register file: two combinational read ports, one edge-triggered write port, debug write counter.
// Reads have zero latency; writes land on the rising edge; no backpressure (always ready).
module register_file_8x16 #(
  parameter int WIDTH   = 16,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [2:0]       RA1,
  input  logic [2:0]       RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [7:0]       WCOUNT
);

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       wcount;
  logic             wr_commit;

  // A write to R0 is dropped entirely when R0 is hardwired, so it neither stores nor counts.
  assign wr_commit = WE && !(R0_ZERO && (WA == 3'd0));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      wcount <= 8'd0;
    end else if (CLR) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      wcount <= 8'd0;
    end else if (wr_commit) begin
      // Per-entry compare keeps an unresolved WA from touching any entry.
      for (int i = 0; i < 8; i++) begin
        if (WA == i[2:0]) regs[i] <= WD;
      end
      wcount <= wcount + 8'd1;
    end
  end

  always_comb begin
    RD1 = regs[RA1];
    if (R0_ZERO && (RA1 == 3'd0)) RD1 = '0;
    if (BYPASS && wr_commit && !CLR && (RA1 == WA)) RD1 = WD;
  end

  always_comb begin
    RD2 = regs[RA2];
    if (R0_ZERO && (RA2 == 3'd0)) RD2 = '0;
    if (BYPASS && wr_commit && !CLR && (RA2 == WA)) RD2 = WD;
  end

  assign WCOUNT = wcount;

endmodule

// File: tb/tb_register_file_8x16.sv
// Bench for register_file_8x16: two instances (R0 hardwired/no bypass, R0 normal/bypass) share stimulus
// and are checked each cycle against an array model, plus literal checks from the directed scenarios.
module tb_register_file_8x16;

  logic        CLK;
  logic        RST_N;
  logic        CLR;
  logic        WE;
  logic [2:0]  WA;
  logic [15:0] WD;
  logic [2:0]  RA1;
  logic [2:0]  RA2;
  logic [15:0] rd1_o [2];
  logic [15:0] rd2_o [2];
  logic [7:0]  wc_o  [2];

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  register_file_8x16 #(.WIDTH(16), .R0_ZERO(1'b1), .BYPASS(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .WE(WE), .WA(WA), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(rd1_o[0]), .RD2(rd2_o[0]), .WCOUNT(wc_o[0])
  );

  register_file_8x16 #(.WIDTH(16), .R0_ZERO(1'b0), .BYPASS(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .WE(WE), .WA(WA), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(rd1_o[1]), .RD2(rd2_o[1]), .WCOUNT(wc_o[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: config 0 has R0 hardwired, config 1 has bypass.
  logic [15:0] mreg [2][8];
  int          mcnt [2];

  function automatic bit r0z(int c);
    return (c == 0);
  endfunction

  function automatic bit byp(int c);
    return (c == 1);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    for (int c = 0; c < 2; c++) begin
      if (!RST_N || CLR) begin
        for (int r = 0; r < 8; r++) mreg[c][r] = 16'h0;
        mcnt[c] = 0;
      end else if (WE && !(r0z(c) && WA == 3'd0)) begin
        mreg[c][WA] = WD;
        mcnt[c] = (mcnt[c] + 1) % 256;
      end
    end
  end

  function automatic logic [15:0] exp_rd(int c, logic [2:0] ra);
    if (r0z(c) && ra == 3'd0) return 16'h0;
    if (byp(c) && RST_N && WE && !CLR && ra == WA && !(r0z(c) && WA == 3'd0)) return WD;
    return mreg[c][ra];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("cyc_rd1_dut%0d", c), rd1_o[c], exp_rd(c, RA1));
        chk($sformatf("cyc_rd2_dut%0d", c), rd2_o[c], exp_rd(c, RA2));
        chk($sformatf("cyc_wcount_dut%0d", c), {8'h0, wc_o[c]}, 16'(mcnt[c]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; CLR = 1'b0; WE = 1'b0; WA = 3'd0; WD = 16'h0;
    RA1 = 3'd3; RA2 = 3'd7;
    #12;
    for (int c = 0; c < 2; c++) begin
      chk("reset_rd1", rd1_o[c], 16'h0);
      chk("reset_rd2", rd2_o[c], 16'h0);
      chk("reset_wcount", {8'h0, wc_o[c]}, 16'h0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk_on = 1'b1;

    WE = 1'b1; WA = 3'd3; WD = 16'h00A5;
    tick();
    WE = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("first_write_rd1", rd1_o[c], 16'h00A5);
      chk("first_write_wcount", {8'h0, wc_o[c]}, 16'h1);
    end

    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int k = 1; k < 8; k++) begin
      WE = 1'b1; WA = 3'(k); WD = 16'(16'h1111 * k);
      tick();
    end
    WE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RA1 = 3'(i); RA2 = 3'(7 - i);
      #1;
      for (int c = 0; c < 2; c++) begin
        chk("sweep_rd1", rd1_o[c], 16'(16'h1111 * i));
        chk("sweep_rd2", rd2_o[c], 16'(16'h1111 * (7 - i)));
      end
    end
    for (int c = 0; c < 2; c++) chk("fill_wcount", {8'h0, wc_o[c]}, 16'd7);

    WE = 1'b1; WA = 3'd0; WD = 16'hFFFF; RA1 = 3'd0;
    tick();
    WE = 1'b0;
    #1;
    chk("r0_protect_rd1", rd1_o[0], 16'h0);
    chk("r0_protect_wcount", {8'h0, wc_o[0]}, 16'd7);
    chk("r0_normal_rd1", rd1_o[1], 16'hFFFF);
    chk("r0_normal_wcount", {8'h0, wc_o[1]}, 16'd8);

    WE = 1'b1; WA = 3'd5; RA1 = 3'd5; WD = 16'hBEEF;
    #1;
    chk("rdw_nobypass_before", rd1_o[0], 16'h5555);
    chk("rdw_bypass_same_cycle", rd1_o[1], 16'hBEEF);
    tick();
    WE = 1'b0;
    #1;
    chk("rdw_after_dut0", rd1_o[0], 16'hBEEF);
    chk("rdw_after_dut1", rd1_o[1], 16'hBEEF);

    CLR = 1'b1; WE = 1'b1; WA = 3'd2; WD = 16'h1234; RA1 = 3'd2;
    #1;
    chk("clr_blocks_bypass", rd1_o[1], 16'h2222);
    tick();
    CLR = 1'b0; WE = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("clr_prio_rd1", rd1_o[c], 16'h0);
      chk("clr_prio_wcount", {8'h0, wc_o[c]}, 16'h0);
    end

    for (int n = 0; n < 256; n++) begin
      WE = 1'b1; WA = 3'($urandom_range(1, 7)); WD = 16'($urandom);
      RA1 = 3'($urandom); RA2 = 3'($urandom);
      tick();
    end
    WE = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) chk("wrap_wcount", {8'h0, wc_o[c]}, 16'h0);

    for (int n = 0; n < 300; n++) begin
      WE = 1'($urandom); CLR = ($urandom_range(0, 31) == 0);
      WA = 3'($urandom); WD = 16'($urandom);
      RA1 = 3'($urandom); RA2 = 3'($urandom);
      tick();
    end
    CLR = 1'b0;

    WE = 1'b1; WA = 3'd3; WD = 16'h1357;
    tick();
    WA = 3'd7; WD = 16'h2468;
    tick();
    WE = 1'b0; RA1 = 3'd3; RA2 = 3'd7;
    #1;
    chk("pre_reset_rd1", rd1_o[0], 16'h1357);
    chk("pre_reset_rd2", rd2_o[0], 16'h2468);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("async_reset_rd1", rd1_o[c], 16'h0);
      chk("async_reset_rd2", rd2_o[c], 16'h0);
      chk("async_reset_wcount", {8'h0, wc_o[c]}, 16'h0);
    end
    tick();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
